// File: rtl/dreg_ldcnt_if.sv
// Control/data bundle for the dreg_ldcnt load/step register.
// The master drives enable, op and load data; the slave returns value and status.
interface dreg_ldcnt_if #(
  parameter int unsigned WIDTH = 12
);
  logic             CE;
  logic [1:0]       OP;
  logic [WIDTH-1:0] INna;
  logic [WIDTH-1:0] Outna;
  logic             wrap;
  logic             zero;

  modport master (
    output CE, OP, INna,
    input  Outna, wrap, zero
  );

  modport slave (
    input  CE, OP, INna,
    output Outna, wrap, zero
  );
endinterface

// File: rtl/dreg_ldcnt.sv
// Parametrised PC/MAR-class register: hold, load, increment, decrement with wrap pulse and zero flag.
// Optional macro DREG_LDCNT_SAT_EN makes inc/dec saturate; wrap then flags the saturation hit.
module dreg_ldcnt #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic        clk,
  input  logic        rst,
  dreg_ldcnt_if.slave bus
);
  localparam int unsigned OP_W = 2;
  localparam logic [OP_W-1:0] OP_HOLD = 2'b00;
  localparam logic [OP_W-1:0] OP_LOAD = 2'b01;
  localparam logic [OP_W-1:0] OP_INC  = 2'b10;
  localparam logic [OP_W-1:0] OP_DEC  = 2'b11;

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;
  logic [WIDTH-1:0] w_out_next;
  logic             w_wrap_next;
  logic             w_all_ones;
  logic             w_is_zero;

  assign w_all_ones = (r_out == {WIDTH{1'b1}});
  assign w_is_zero  = (r_out == '0);

  // Next value and wrap pulse; anything unrecognised (incl. X on OP) holds.
  always_comb begin
    w_out_next  = r_out;
    w_wrap_next = 1'b0;
    if (bus.CE) begin
      case (bus.OP)
        OP_HOLD: w_out_next = r_out;
        OP_LOAD: w_out_next = bus.INna;
        OP_INC: begin
          w_wrap_next = w_all_ones;
`ifdef DREG_LDCNT_SAT_EN
          w_out_next  = w_all_ones ? r_out : r_out + WIDTH'(1);
`else
          w_out_next  = r_out + WIDTH'(1);
`endif
        end
        OP_DEC: begin
          w_wrap_next = w_is_zero;
`ifdef DREG_LDCNT_SAT_EN
          w_out_next  = w_is_zero ? r_out : r_out - WIDTH'(1);
`else
          w_out_next  = r_out - WIDTH'(1);
`endif
        end
        default: w_out_next = r_out;
      endcase
    end
  end

  // Reset wins over CE/OP and clears any pending wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= WIDTH'(RESET_VAL);
      r_wrap <= 1'b0;
    end else begin
      r_out  <= w_out_next;
      r_wrap <= w_wrap_next;
    end
  end

  // An undefined op while enabled is a protocol violation by the driver.
  always_ff @(posedge clk) begin
    if (!rst && bus.CE) begin
      assert (!$isunknown(bus.OP));
    end
  end

  assign bus.Outna = r_out;
  assign bus.wrap  = r_wrap;
  assign bus.zero  = w_is_zero;
endmodule
